fix_tx_trailer: RTL
===================

Name: fix_tx_trailer

Overview:
Transmit-side counterpart of the receive checksum block in the FIX parser datapath. It accepts an outgoing FIX message body as a byte stream and forwards it unchanged. It keeps a running modulo-256 byte sum and, after the last body byte, appends the standard trailer "10=NNN<SOH>", where NNN is the sum as three zero-padded ASCII decimal digits. It sits between the message builder and the line/MAC interface.

Parameters:
SOH_CHAR, 8'h01, field delimiter byte emitted as the final trailer byte.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_data_i  input  8  body byte
in_valid_i  input  1  body byte valid
in_start_i  input  1  qualifies first byte of message (with in_valid_i)
in_end_i  input  1  qualifies last body byte, which must be the SOH after the last field (with in_valid_i)
in_ready_o  output  1  block accepts body byte this cycle
out_data_o  output  8  transmitted byte
out_valid_o  output  1  out_data_o valid
out_ready_i  input  1  downstream accepts byte
out_last_o  output  1  marks final trailer SOH
checksum_o  output  8  latched checksum of last message
checksum_valid_o  output  1  one-cycle pulse when checksum_o updates
frame_err_o  output  1  one-cycle pulse on framing error

Behaviour:
- One clock domain. Reset is synchronous and active-high; the ports are clk and rst.
- Reset values:
  - out_valid_o, out_last_o, checksum_valid_o and frame_err_o are 0.
  - out_data_o and checksum_o are 8'h00.
  - Running sum is 0 and the state is IDLE.
- Output register: out_* are registered, giving one cycle of latency from input accept to out_valid_o.
  - The register loads when (!out_valid_o || out_ready_i).
  - out_valid_o holds, and out_data_o and out_last_o stay stable, while out_ready_i is low.
- in_ready_o = (state is IDLE or BODY) && (!out_valid_o || out_ready_i). This is combinational and does not depend on in_valid_i.
- Input accept = in_valid_i && in_ready_o.
- States: IDLE, BODY, TAG1, TAG0, EQ, D2, D1, D0, TSOH.
- IDLE:
  - Accept with in_start_i: forward the byte and set sum = byte. Go to BODY, or go to TAG1 if in_end_i is also set.
  - Accept without in_start_i: drop the byte (no output), pulse frame_err_o, stay in IDLE.
- BODY:
  - Accept: forward the byte and set sum = sum + byte, mod 256 (8-bit wrap).
  - If in_end_i is set: latch the final sum into checksum_o, pulse checksum_valid_o in the next cycle, and go to TAG1.
  - If in_start_i is set in BODY: pulse frame_err_o, restart sum = byte, and forward the byte. This abandons the previous message; no trailer is sent for it.
- Trailer states TAG1 through TSOH:
  - in_ready_o = 0.
  - Each state loads one byte into the output register when the register is free, then advances.
  - Bytes in order: TAG1 8'h31 ('1'), TAG0 8'h30 ('0'), EQ 8'h3D ('='), D2 hundreds+8'h30, D1 tens+8'h30, D0 units+8'h30, TSOH SOH_CHAR with out_last_o=1.
  - After TSOH the state goes to IDLE.
  - The trailer bytes are not added to the sum.
- Decimal split is taken from the latched checksum:
  - hundreds in 0..2; tens and units in 0..9.
  - Zero padding is mandatory (5 -> "005").
  - Implemented with compare/subtract logic, no divider.
- The next message may be accepted in the cycle after TSOH loads, when in IDLE and the register is free.
- Reset mid-message discards any partial message and pending trailer; no output is produced after reset.
- When the output register is full and not draining, no byte is accepted and no state advance occurs.

Decomposition:
- Package fix_pkg:
  - Characters: FIX_SOH, ASCII_0, ASCII_1, ASCII_EQ.
  - State enum typedef tx_trailer_state_t.
- One sub-module, fix_bin2dec3: combinational 8-bit to three 4-bit BCD digits, reusable by the receive side for checksum-field compare.

Test Plan:
- Basic: send 0x38,0x3D,0x41,0x01 (start on first byte, end on last) with out_ready_i=1 -> output is those 4 bytes then 31,30,3D,31,38,33,01 ("183"); out_last_o on final byte; checksum_o=0xB7 with checksum_valid_o pulse.
- Wrap/padding: send 0xFF,0xFF,0x03 -> sum 0x01, trailer digits 30,30,31 ("001").
- Single-byte message: 0x01 with start and end both set -> 01 then 31,30,3D,30,30,31,01.
- Backpressure: as the Basic test, but toggle out_ready_i randomly -> identical byte sequence; out_data_o stable while stalled; in_ready_o low through the entire trailer.
- Framing:
  - Byte in IDLE without start -> dropped and frame_err_o pulses.
  - Start in BODY -> frame_err_o pulses, sum restarts, and only the new message gets a trailer.
- Reset mid-trailer: assert rst during D1 -> next cycle out_valid_o=0 and state IDLE; a subsequent message gets a correct trailer.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared FIX datapath constants and the transmit trailer state type.
package fix_pkg;

    localparam logic [7:0] FIX_SOH  = 8'h01;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BODY,
        ST_TAG1,
        ST_TAG0,
        ST_EQ,
        ST_D2,
        ST_D1,
        ST_D0,
        ST_TSOH
    } tx_trailer_state_t;

endpackage

// File: rtl/fix_tx_trailer_if.sv
// Byte-stream handshake between message builder, trailer block and line side.
interface fix_tx_trailer_if;

    logic [7:0] in_data_i;
    logic       in_valid_i;
    logic       in_start_i;
    logic       in_end_i;
    logic       in_ready_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       out_last_o;

    // The trailer block itself: consumes the body stream, produces the line stream.
    modport slave (
        input  in_data_i, in_valid_i, in_start_i, in_end_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o, out_last_o
    );

    // The surrounding logic: drives the body stream, sinks the line stream.
    modport master (
        output in_data_i, in_valid_i, in_start_i, in_end_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o, out_last_o
    );

endinterface

// File: rtl/fix_bin2dec3.sv
// Combinational 8-bit binary to three BCD digits (hundreds 0..2, tens, units).
module fix_bin2dec3 (
    input  logic [7:0] bin_i,
    output logic [3:0] hundreds_o,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic [7:0] rem_h;

    // Compare/subtract cascade: strip hundreds first, then find the largest tens multiple.
    always_comb begin
        hundreds_o = 4'd0;
        rem_h      = bin_i;
        if (bin_i >= 8'd200) begin
            hundreds_o = 4'd2;
            rem_h      = bin_i - 8'd200;
        end else if (bin_i >= 8'd100) begin
            hundreds_o = 4'd1;
            rem_h      = bin_i - 8'd100;
        end
        tens_o  = 4'd0;
        units_o = rem_h[3:0];
        for (int i = 1; i < 10; i++) begin
            if (rem_h >= 8'(i * 10)) begin
                tens_o  = 4'(i);
                units_o = 4'(rem_h - 8'(i * 10));
            end
        end
    end

endmodule

// File: rtl/fix_tx_trailer.sv
// Forwards an outgoing FIX body and appends "10=NNN<SOH>" from the running byte sum.
module fix_tx_trailer
    import fix_pkg::*;
#(
    parameter logic [7:0] SOH_CHAR = FIX_SOH
) (
    input  logic             clk,
    input  logic             rst,
    fix_tx_trailer_if.slave  bus,
    output logic [7:0]       checksum_o,
    output logic             checksum_valid_o,
    output logic             frame_err_o
);

    tx_trailer_state_t state_q, state_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] checksum_q, checksum_d;
    logic       checksum_valid_q, checksum_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;

    logic       reg_free;
    logic       in_ready;
    logic       accept;
    logic [7:0] body_sum;
    logic [3:0] dig_h, dig_t, dig_u;

    assign reg_free = !out_valid_q || bus.out_ready_i;
    assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_BODY)) && reg_free;
    assign accept   = bus.in_valid_i && in_ready;
    // A start byte always restarts the sum, even when it abandons a message in BODY.
    assign body_sum = bus.in_start_i ? bus.in_data_i : (sum_q + bus.in_data_i);

    fix_bin2dec3 u_bin2dec3 (
        .bin_i      (checksum_q),
        .hundreds_o (dig_h),
        .tens_o     (dig_t),
        .units_o    (dig_u)
    );

    // Next-state logic: body forwarding, sum tracking and trailer byte sequencing.
    always_comb begin
        state_d          = state_q;
        sum_d            = sum_q;
        checksum_d       = checksum_q;
        checksum_valid_d = 1'b0;
        frame_err_d      = 1'b0;
        out_data_d       = out_data_q;
        out_valid_d      = out_valid_q;
        out_last_d       = out_last_q;
        if (reg_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.in_start_i) begin
                        out_data_d  = bus.in_data_i;
                        out_valid_d = 1'b1;
                        sum_d       = bus.in_data_i;
                        if (bus.in_end_i) begin
                            checksum_d       = bus.in_data_i;
                            checksum_valid_d = 1'b1;
                            state_d          = ST_TAG1;
                        end else begin
                            state_d = ST_BODY;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    out_data_d  = bus.in_data_i;
                    out_valid_d = 1'b1;
                    sum_d       = body_sum;
                    frame_err_d = bus.in_start_i;
                    if (bus.in_end_i) begin
                        checksum_d       = body_sum;
                        checksum_valid_d = 1'b1;
                        state_d          = ST_TAG1;
                    end
                end
            end
            ST_TAG1: if (reg_free) begin
                out_data_d  = ASCII_1;
                out_valid_d = 1'b1;
                state_d     = ST_TAG0;
            end
            ST_TAG0: if (reg_free) begin
                out_data_d  = ASCII_0;
                out_valid_d = 1'b1;
                state_d     = ST_EQ;
            end
            ST_EQ: if (reg_free) begin
                out_data_d  = ASCII_EQ;
                out_valid_d = 1'b1;
                state_d     = ST_D2;
            end
            ST_D2: if (reg_free) begin
                out_data_d  = ASCII_0 + {4'h0, dig_h};
                out_valid_d = 1'b1;
                state_d     = ST_D1;
            end
            ST_D1: if (reg_free) begin
                out_data_d  = ASCII_0 + {4'h0, dig_t};
                out_valid_d = 1'b1;
                state_d     = ST_D0;
            end
            ST_D0: if (reg_free) begin
                out_data_d  = ASCII_0 + {4'h0, dig_u};
                out_valid_d = 1'b1;
                state_d     = ST_TSOH;
            end
            ST_TSOH: if (reg_free) begin
                out_data_d  = SOH_CHAR;
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any partial message and pending trailer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            sum_q            <= 8'h00;
            checksum_q       <= 8'h00;
            checksum_valid_q <= 1'b0;
            frame_err_q      <= 1'b0;
            out_data_q       <= 8'h00;
            out_valid_q      <= 1'b0;
            out_last_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            sum_q            <= sum_d;
            checksum_q       <= checksum_d;
            checksum_valid_q <= checksum_valid_d;
            frame_err_q      <= frame_err_d;
            out_data_q       <= out_data_d;
            out_valid_q      <= out_valid_d;
            out_last_q       <= out_last_d;
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.out_data_o   = out_data_q;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_last_o   = out_last_q;
    assign checksum_o       = checksum_q;
    assign checksum_valid_o = checksum_valid_q;
    assign frame_err_o      = frame_err_q;

endmodule
